dev_port_fifo: RTL
==================

# dev_port_fifo

Per-device port buffer between a device agent and the `bs_gnrtr_n_rbtr` bus. One instance per bus port. It holds a TX queue that presents `pndng`/`D_pop` to the bus and drains on `pop`. It also holds an RX queue that captures `push`/`D_push` from the bus for the device to read, with sticky overflow reporting on both directions.

## Interface

Parameters:

- `PCKG_SZ`, 16: packet width in bits.
- `DEPTH`, 8: entries per queue. Must be a power of two and ≥ 2.
- `ADDR_W`, 8: width of the destination field, which occupies `[PCKG_SZ-1 -: ADDR_W]`.
- `DEV_ID`, 0: this port's address.
- `BCAST`, 8'hFF: broadcast destination value.

Ports (clock and reset first):

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pndng` out 1: TX queue non-empty (to bus).
- `D_pop` out PCKG_SZ: TX head packet (to bus).
- `pop` in 1: bus consumes the TX head.
- `push` in 1: bus delivers a packet.
- `D_push` in PCKG_SZ: delivered packet.
- `tx_wr` in 1: device enqueues a packet for transmission.
- `tx_data` in PCKG_SZ: packet to enqueue.
- `tx_full` out 1: TX queue full.
- `tx_cnt` out $clog2(DEPTH)+1: TX occupancy.
- `rx_rd` in 1: device consumes the RX head.
- `rx_data` out PCKG_SZ: RX head packet.
- `rx_vld` out 1: RX queue non-empty.
- `rx_cnt` out $clog2(DEPTH)+1: RX occupancy.
- `tx_ovf` out 1: sticky; a write was dropped because TX was full.
- `rx_ovf` out 1: sticky; a push was dropped because RX was full.
- `misroute_cnt` out 8: count of dropped misaddressed pushes. Saturates at 255.

## Operation

- Both queues are circular buffers with rd/wr pointers of width $clog2(DEPTH) and a separate occupancy counter. Pointers wrap modulo DEPTH.
- Both queues are show-ahead: the head is valid on `D_pop`/`rx_data` whenever `pndng`/`rx_vld` is 1.
  - `D_pop` and `rx_data` are driven to 0 when their queue is empty.
- TX write is accepted when `tx_wr` = 1 and (`tx_cnt` < DEPTH or `pop` = 1 in the same cycle).
  - Otherwise the write is dropped and `tx_ovf` is set.
- TX pop is honoured only when `pndng` = 1. A `pop` while empty is ignored: no pointer or count change, no flag.
- Simultaneous accepted write and pop: the count is unchanged and both pointers advance. This covers the full case, where the pop frees the slot.
- Write while empty with `pop` = 1: the pop is ignored and the write is accepted.
- RX mirrors TX, with `push`/`D_push` as the write side and `rx_rd` as the read side. `rx_ovf` is set on a dropped push.
- `tx_full` = (`tx_cnt` == DEPTH).
- Overflow flags stay set until reset.
- `misroute_cnt` is active only with the configuration macro enabled (see Configuration).

## Timing

- Reset value of every output is 0: `pndng`, `D_pop`, `tx_full`, `tx_cnt`, `rx_data`, `rx_vld`, `rx_cnt`, `tx_ovf`, `rx_ovf`, `misroute_cnt`.
- Asserting `reset` at any time immediately clears pointers, counts and flags. Storage contents are not cleared but are never visible, because empty forces the data outputs to 0.
- Write latency is one cycle. A write accepted at edge N makes `pndng` (or `rx_vld`) = 1 and the packet visible from just after edge N.
- Pop/read at edge N presents the next entry from just after edge N. If the queue becomes empty, the flag drops after N.
- The bus may hold `pop` high every cycle; back-to-back pops drain one entry per cycle.
- `tx_cnt`, `rx_cnt`, `tx_full` and the flags are registered and update on the same edge as the accepted operation.

## Configuration

The macro is `DEV_PORT_FIFO_ADDR_CHECK_EN`.

- Defined:
  - An RX push whose destination field ≠ `DEV_ID` and ≠ `BCAST` is dropped. It is not stored and does not set `rx_ovf`.
  - `misroute_cnt` increments by 1 per such drop, saturating at 255.
  - The misroute check takes priority over the full check.
- Undefined:
  - Every push is subject only to the full check.
  - `misroute_cnt` is tied to 0.

## Structure

- Package `dev_port_pkg`:
  - Default `ADDR_W` and `BCAST` values.
  - A `dest_of()` function that extracts the destination field.
  - The counter-width localparam expression.
- Sub-module `port_fifo_core`:
  - Parameterised show-ahead circular FIFO providing wr/rd/data/cnt/full/empty/ovf.
  - Instantiated twice, once for TX and once for RX.
- The top level contains the RX address filter, the misroute counter and the port mapping.

## Test plan

- Reset, then `tx_wr` with 16'h0201 for one cycle → next cycle `pndng` = 1, `D_pop` = 16'h0201, `tx_cnt` = 1. Then `pop` → `pndng` = 0, `D_pop` = 0.
- Fill TX with 8 writes (DEPTH = 8) → `tx_full` = 1. A 9th write is dropped and `tx_ovf` = 1. Then 8 pops return the entries in write order across the pointer wrap.
- TX full, `tx_wr` = 1 and `pop` = 1 in the same cycle → `tx_cnt` stays 8, `tx_ovf` stays 0, and the new packet appears last.
- `pop` pulsed while TX is empty, and `rx_rd` pulsed while RX is empty → no count change, no flags set.
- With `DEV_PORT_FIFO_ADDR_CHECK_EN` and `DEV_ID` = 3, push 16'h0301, 16'hFF02, 16'h0504 → `rx_cnt` = 2, `misroute_cnt` = 1, and reads return 16'h0301 then 16'hFF02.
- Assert `reset` asynchronously mid-cycle with both queues at count 5 → all outputs are 0 immediately, without waiting for a clock edge. After reset, normal operation resumes with no stale data visible.

Source files
------------

// File: rtl/dev_port_pkg.sv
// rtl/dev_port_pkg.sv - shared defaults and helpers for dev_port_fifo
`timescale 1ns/1ps
package dev_port_pkg;

    localparam int          DEF_ADDR_W = 8;
    localparam logic [7:0]  DEF_BCAST  = 8'hFF;
    localparam int          MAX_W      = 64;

    // Occupancy counter width: one extra bit so a full queue (cnt == DEPTH) is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Destination field sits in the top addr_w bits of a pkt_sz-bit packet.
    function automatic logic [MAX_W-1:0] dest_of(input logic [MAX_W-1:0] pkt,
                                                 input int pkt_sz,
                                                 input int addr_w);
        logic [MAX_W-1:0] mask;
        mask = (MAX_W'(1) << addr_w) - MAX_W'(1);
        return (pkt >> (pkt_sz - addr_w)) & mask;
    endfunction

endpackage

// File: rtl/port_fifo_core.sv
// rtl/port_fifo_core.sv - show-ahead circular FIFO with occupancy count and sticky overflow
// Ports: clk, reset (async, active-high); wr/wr_data write side; rd/rd_data show-ahead
// read side (rd_data is 0 while empty); cnt occupancy; full/empty status; ovf sticky drop flag.
`timescale 1ns/1ps
module port_fifo_core
    import dev_port_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr,
    input  logic [W-1:0]              wr_data,
    input  logic                      rd,
    output logic [W-1:0]              rd_data,
    output logic [cnt_w(DEPTH)-1:0]   cnt,
    output logic                      full,
    output logic                      empty,
    output logic                      ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

    // A read on an empty queue is ignored; a read on a full queue frees the
    // slot so a same-cycle write is still accepted.
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (wr && !do_wr) ovf <= 1'b1;
        end
    end

    // Storage is never reset; empty masks stale contents on the output.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dev_port_fifo.sv
// rtl/dev_port_fifo.sv - per-device bus port with TX/RX queues, overflow flags and RX address filter
// Ports: clk, reset (async, active-high); bus side pndng/D_pop/pop and push/D_push;
// device side tx_wr/tx_data/tx_full/tx_cnt and rx_rd/rx_data/rx_vld/rx_cnt;
// status tx_ovf, rx_ovf, misroute_cnt.
// Macro DEV_PORT_FIFO_ADDR_CHECK_EN: drop RX pushes not addressed to DEV_ID or BCAST
// and count them in misroute_cnt; otherwise misroute_cnt is 0.
`timescale 1ns/1ps
module dev_port_fifo
    import dev_port_pkg::*;
#(
    parameter int                PCKG_SZ = 16,
    parameter int                DEPTH   = 8,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                DEV_ID  = 0,
    parameter logic [ADDR_W-1:0] BCAST   = ADDR_W'(DEF_BCAST)
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      pndng,
    output logic [PCKG_SZ-1:0]        D_pop,
    input  logic                      pop,
    input  logic                      push,
    input  logic [PCKG_SZ-1:0]        D_push,
    input  logic                      tx_wr,
    input  logic [PCKG_SZ-1:0]        tx_data,
    output logic                      tx_full,
    output logic [cnt_w(DEPTH)-1:0]   tx_cnt,
    input  logic                      rx_rd,
    output logic [PCKG_SZ-1:0]        rx_data,
    output logic                      rx_vld,
    output logic [cnt_w(DEPTH)-1:0]   rx_cnt,
    output logic                      tx_ovf,
    output logic                      rx_ovf,
    output logic [7:0]                misroute_cnt
);

    logic              tx_empty;
    logic              rx_empty;
    logic              rx_full;
    logic              unused_rx_full;
    logic [ADDR_W-1:0] dest;
    logic              addr_ok;
    logic              rx_wr;

    assign dest    = ADDR_W'(dest_of(MAX_W'(D_push), PCKG_SZ, ADDR_W));
    assign addr_ok = (dest == ADDR_W'(DEV_ID)) || (dest == BCAST);

`ifdef DEV_PORT_FIFO_ADDR_CHECK_EN
    logic [7:0] mis_q;

    // Misaddressed pushes never reach the RX queue, so they can't count as overflow.
    assign rx_wr = push & addr_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mis_q <= 8'd0;
        else if (push && !addr_ok && mis_q != 8'hFF)
            mis_q <= mis_q + 8'd1;
    end

    assign misroute_cnt = mis_q;
`else
    logic unused_addr_ok;

    assign unused_addr_ok = addr_ok;
    assign rx_wr          = push;
    assign misroute_cnt   = 8'd0;
`endif

    assign unused_rx_full = rx_full;

    port_fifo_core #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_tx (
        .clk     (clk),
        .reset   (reset),
        .wr      (tx_wr),
        .wr_data (tx_data),
        .rd      (pop),
        .rd_data (D_pop),
        .cnt     (tx_cnt),
        .full    (tx_full),
        .empty   (tx_empty),
        .ovf     (tx_ovf)
    );

    port_fifo_core #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .wr      (rx_wr),
        .wr_data (D_push),
        .rd      (rx_rd),
        .rd_data (rx_data),
        .cnt     (rx_cnt),
        .full    (rx_full),
        .empty   (rx_empty),
        .ovf     (rx_ovf)
    );

    assign pndng  = ~tx_empty;
    assign rx_vld = ~rx_empty;

endmodule
